// File: rtl/simon_pkg.sv
// Shared types and defaults for the four-colour memory game autoplayer.
package simon_pkg;

    localparam int unsigned SIMON_DEPTH     = 32;
    localparam int unsigned SIMON_ADDR_W    = 5;
    localparam int unsigned SIMON_WD_CYCLES = 255;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } colour_t;

    typedef enum logic [3:0] {
        IDLE,
        START,
        OBS_ON,
        OBS_OFF,
        KEY,
        ECHO_OFF,
        WON,
        LOST,
        FAULT
    } state_t;

    typedef struct packed {
        logic    invalid;
        colour_t colour;
    } led_decode_t;

    // Anything other than exactly one lit LED is flagged invalid.
    function automatic led_decode_t decode_led(input logic [3:0] leds);
        led_decode_t d;
        d.invalid = 1'b0;
        d.colour  = RED;
        unique case (leds)
            4'b0001: d.colour = RED;
            4'b0010: d.colour = GREEN;
            4'b0100: d.colour = YELLOW;
            4'b1000: d.colour = BLUE;
            default: d.invalid = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic [3:0] colour_onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_autoplayer_if.sv
// Game-facing bus: LED/loss indications from the game, start/key requests to it.
interface simon_autoplayer_if;
    logic [3:0] nl;
    logic       nloss;
    logic       start;
    logic [3:0] k;

    modport master (input nl, input nloss, output start, output k);
    modport slave  (output nl, output nloss, input start, input k);
endinterface

// File: rtl/simon_seq_mem.sv
// Colour sequence store: one write port, one asynchronous read port.
module simon_seq_mem
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH  = SIMON_DEPTH,
    parameter int unsigned ADDR_W = SIMON_ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  colour_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output colour_t           rdata
);

    colour_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/simon_autoplayer.sv
// Self-playing opponent: watches LED playback, records it, replays it on the keys.
module simon_autoplayer
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH     = SIMON_DEPTH,
    parameter int unsigned ADDR_W    = SIMON_ADDR_W,
    parameter int unsigned WD_CYCLES = SIMON_WD_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                inject_err,
    simon_autoplayer_if.master  game,
    output logic [ADDR_W:0]     round,
    output logic                busy,
    output logic                won,
    output logic                lost,
    output logic                fault
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned WD_W  = $clog2(WD_CYCLES + 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  obs_cnt, obs_cnt_n;
    logic [CNT_W-1:0]  key_idx, key_idx_n;
    logic [CNT_W-1:0]  round_n;
    logic [WD_W-1:0]   wd_cnt, wd_cnt_n;
    logic              inj, inj_n;
    logic              start_n, busy_n, won_n, lost_n, fault_n;
    logic [3:0]        k_n;

    led_decode_t       led;
    colour_t           rd_colour, key_colour;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;

    assign led = decode_led(game.nl);

    // Injection corrupts only the first key of the round it was latched for.
    assign key_colour = colour_t'(rd_colour + ((inj && key_idx == '0) ? 2'd1 : 2'd0));

    simon_seq_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (ADDR_W'(obs_cnt)),
        .wdata (led.colour),
        .raddr (mem_raddr),
        .rdata (rd_colour)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            obs_cnt    <= '0;
            key_idx    <= '0;
            wd_cnt     <= '0;
            inj        <= 1'b0;
            round      <= '0;
            busy       <= 1'b0;
            won        <= 1'b0;
            lost       <= 1'b0;
            fault      <= 1'b0;
            game.start <= 1'b0;
            game.k     <= '0;
        end else begin
            state      <= state_n;
            obs_cnt    <= obs_cnt_n;
            key_idx    <= key_idx_n;
            wd_cnt     <= wd_cnt_n;
            inj        <= inj_n;
            round      <= round_n;
            busy       <= busy_n;
            won        <= won_n;
            lost       <= lost_n;
            fault      <= fault_n;
            game.start <= start_n;
            game.k     <= k_n;
        end
    end

    always_comb begin
        state_n   = state;
        obs_cnt_n = obs_cnt;
        key_idx_n = key_idx;
        wd_cnt_n  = '0;
        inj_n     = inj;
        round_n   = round;
        won_n     = won;
        lost_n    = lost;
        fault_n   = fault;
        k_n       = '0;
        mem_we    = 1'b0;
        // Single read port: key replay in KEY, playback check everywhere else.
        mem_raddr = (state == KEY) ? ADDR_W'(key_idx) : ADDR_W'(obs_cnt);

        unique case (state)
            IDLE, WON, LOST, FAULT: begin
                if (go) state_n = START;
            end
            START: begin
                obs_cnt_n = '0;
                state_n   = OBS_ON;
            end
            OBS_ON: begin
                if (game.nloss) begin
                    state_n = LOST;
                end else if (game.nl != 4'b0000) begin
                    if (led.invalid) begin
                        state_n = FAULT;
                    end else if (obs_cnt < round) begin
                        state_n = (led.colour != rd_colour) ? FAULT : OBS_OFF;
                    end else begin
                        mem_we  = 1'b1;
                        state_n = OBS_OFF;
                    end
                end else if (wd_cnt == WD_W'(WD_CYCLES - 1)) begin
                    state_n = FAULT;
                end else begin
                    wd_cnt_n = wd_cnt + WD_W'(1);
                end
            end
            OBS_OFF: begin
                if (game.nloss) begin
                    state_n = LOST;
                end else if (game.nl != 4'b0000) begin
                    if (led.invalid) state_n = FAULT;
                end else begin
                    obs_cnt_n = obs_cnt + CNT_W'(1);
                    if (obs_cnt_n == round + CNT_W'(1)) begin
                        key_idx_n = '0;
                        inj_n     = inject_err;
                        state_n   = KEY;
                    end else begin
                        state_n = OBS_ON;
                    end
                end
            end
            KEY: begin
                if (game.nloss) begin
                    state_n = LOST;
                end else if (game.nl != 4'b0000) begin
                    state_n = (led.invalid || led.colour != key_colour) ? FAULT : ECHO_OFF;
                end else begin
                    k_n = colour_onehot(key_colour);
                end
            end
            ECHO_OFF: begin
                if (game.nloss) begin
                    state_n = LOST;
                end else if (game.nl != 4'b0000) begin
                    if (led.invalid) state_n = FAULT;
                end else if (key_idx == round) begin
                    round_n   = (round == CNT_W'(DEPTH)) ? round : round + CNT_W'(1);
                    obs_cnt_n = '0;
                    state_n   = (round_n == CNT_W'(DEPTH)) ? WON : OBS_ON;
                end else begin
                    key_idx_n = key_idx + CNT_W'(1);
                    state_n   = KEY;
                end
            end
            default: state_n = IDLE;
        endcase

        // Flags and pulses follow the state being entered so they register with it.
        if (state_n == START) begin
            round_n = '0;
            won_n   = 1'b0;
            lost_n  = 1'b0;
            fault_n = 1'b0;
        end
        if (state_n == WON)   won_n   = 1'b1;
        if (state_n == LOST)  lost_n  = 1'b1;
        if (state_n == FAULT) fault_n = 1'b1;
        start_n = (state_n == START);
        busy_n  = state_n inside {START, OBS_ON, OBS_OFF, KEY, ECHO_OFF};
    end

endmodule
